// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and helpers for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int DEFAULT_ADDR_W = 22;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    // Minimum of one bit so a single-entry index still has a legal width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// rtl/sdram_arb_tag_fifo.sv - in-order FIFO of read owner indices
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int TAG_W = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign head  = mem_q[rd_ptr_q];

    // A pop frees the slot the push needs, so push is accepted even when full.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_tag;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin sharing of one SDRAM controller slave port
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MAX_PENDING = 8
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic [ADDR_W-1:0]               s_address,
    output logic                            s_read,
    output logic                            s_write,
    output logic [DATA_W-1:0]               s_writedata,
    output logic [DATA_W/8-1:0]             s_byteenable,
    input  logic                            s_waitrequest,
    input  logic [DATA_W-1:0]               s_readdata,
    input  logic                            s_readdatavalid,
    output logic                            err_rdv_unexpected
);

    localparam int BE_W = DATA_W / 8;
    localparam int OW   = clog2(NUM_MASTERS);

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [ADDR_W-1:0] s_address_q, s_address_d;
    logic [DATA_W-1:0] s_writedata_q, s_writedata_d;
    logic [BE_W-1:0]   s_byteenable_q, s_byteenable_d;
    logic              s_read_q, s_read_d;
    logic              s_write_q, s_write_d;
    logic              err_q, err_d;

    logic [NUM_MASTERS-1:0] rd_ok, elig;
    logic                   win_found;
    logic [OW-1:0]          win_idx;
    int                     cand;
    logic                   accept;
    logic                   fifo_full, fifo_empty;
    logic [OW-1:0]          fifo_head;

    assign accept             = (state_q == ST_ISSUE) && !s_waitrequest;
    assign s_address          = s_address_q;
    assign s_read             = s_read_q;
    assign s_write            = s_write_q;
    assign s_writedata        = s_writedata_q;
    assign s_byteenable       = s_byteenable_q;
    assign m_readdata         = s_readdata;
    assign err_rdv_unexpected = err_q;

    sdram_arb_tag_fifo #(
        .TAG_W (OW),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (accept && s_read_q),
        .push_tag (owner_q),
        .pop      (s_readdatavalid),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Reads need a free tag slot; writes never touch the FIFO.
    always_comb begin
        rd_ok     = m_read & {NUM_MASTERS{~fifo_full}};
        elig      = rd_ok | m_write;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = OW'(cand);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        s_address_d    = s_address_q;
        s_writedata_d  = s_writedata_q;
        s_byteenable_d = s_byteenable_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        err_d          = err_q | (s_readdatavalid & fifo_empty);
        case (state_q)
            ST_IDLE: begin
                s_read_d  = 1'b0;
                s_write_d = 1'b0;
                if (win_found) begin
                    owner_d        = win_idx;
                    s_address_d    = m_address[int'(win_idx)*ADDR_W +: ADDR_W];
                    s_writedata_d  = m_writedata[int'(win_idx)*DATA_W +: DATA_W];
                    s_byteenable_d = m_byteenable[int'(win_idx)*BE_W +: BE_W];
                    s_read_d       = rd_ok[win_idx];
                    s_write_d      = ~rd_ok[win_idx] & m_write[win_idx];
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!s_waitrequest) begin
                    rr_ptr_d  = (owner_q == OW'(NUM_MASTERS-1)) ? '0 : owner_q + 1'b1;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            s_address_q    <= '0;
            s_writedata_q  <= '0;
            s_byteenable_q <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            s_address_q    <= s_address_d;
            s_writedata_q  <= s_writedata_d;
            s_byteenable_q <= s_byteenable_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            err_q          <= err_d;
        end
    end

    // Release and read-return strobes follow the controller with no added latency.
    always_comb begin
        m_waitrequest = '1;
        if (accept) begin
            m_waitrequest[owner_q] = 1'b0;
        end
        m_readdatavalid = '0;
        if (s_readdatavalid && !fifo_empty) begin
            m_readdatavalid[fifo_head] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed vector bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int BW = 2;

    logic            clk_clk = 1'b0;
    logic            reset_reset_n;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_read, m_write;
    logic [N*DW-1:0] m_writedata;
    logic [N*BW-1:0] m_byteenable;
    logic [N-1:0]    m_waitrequest, m_readdatavalid;
    logic [DW-1:0]   m_readdata;
    logic [AW-1:0]   s_address;
    logic            s_read, s_write;
    logic [DW-1:0]   s_writedata;
    logic [BW-1:0]   s_byteenable;
    logic            s_waitrequest;
    logic [DW-1:0]   s_readdata;
    logic            s_readdatavalid;
    logic            err_rdv_unexpected;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(8)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_rdv_unexpected(err_rdv_unexpected)
    );

    // Controller model: returns canned data three edges after each accepted read.
    logic          model_en, tb_rdv;
    logic [DW-1:0] tb_rdata, pd0, pd1, pd2;
    logic [2:0]    pv;
    int            model_cnt;
    logic [DW-1:0] ret_data [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};

    assign s_readdatavalid = model_en ? pv[2] : tb_rdv;
    assign s_readdata      = model_en ? pd2   : tb_rdata;

    always @(posedge clk_clk) begin
        if (!model_en) begin
            pv        <= '0;
            model_cnt <= 0;
        end else begin
            pv  <= {pv[1:0], s_read && !s_waitrequest};
            pd0 <= ret_data[model_cnt[1:0]];
            pd1 <= pd0;
            pd2 <= pd1;
            if (s_read && !s_waitrequest) model_cnt <= model_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        m_read[m]               = rd;
        m_write[m]              = wr;
        m_address[m*AW +: AW]   = a;
        m_writedata[m*DW +: DW] = d;
        m_byteenable[m*BW +: BW] = be;
    endtask

    task automatic clear_req();
        m_read = '0; m_write = '0; m_address = '0; m_writedata = '0; m_byteenable = '0;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        clear_req();
        s_waitrequest = 1'b0;
        tb_rdv = 1'b0;
        tb_rdata = '0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
    endtask

    task automatic issue_read(input int m, input logic [AW-1:0] a);
        logic [N-1:0] e;
        set_req(m, 1'b1, 1'b0, a, '0, '1);
        s_waitrequest = 1'b0;
        @(posedge clk_clk);
        @(negedge clk_clk);
        e = '1; e[m] = 1'b0;
        check("issue_rd_release", m_waitrequest, e);
        @(posedge clk_clk); #1;
        clear_req();
        @(negedge clk_clk);
    endtask

    typedef struct {
        int            m;
        logic          rd, wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic          exp_rd, exp_wr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e;
        int gi, rets, found;
        int acc [N];
        int exp_grant [4];
        logic [N-1:0] exp_rdv [4];

        model_en = 1'b0;
        vecs[0] = '{0, 1'b0, 1'b1, 22'h012345, 16'hBEEF, 2'b11, 1'b0, 1'b1};
        vecs[1] = '{1, 1'b0, 1'b1, 22'h3FFFFF, 16'h0001, 2'b10, 1'b0, 1'b1};
        vecs[2] = '{0, 1'b1, 1'b0, 22'h000000, 16'h0000, 2'b11, 1'b1, 1'b0};
        vecs[3] = '{1, 1'b1, 1'b1, 22'h2AAAAA, 16'h7777, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{1, 1'b0, 1'b1, 22'h155555, 16'h5A5A, 2'b01, 1'b0, 1'b1};

        do_reset();
        check("rst_s_read", s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_s_address", s_address, 0);
        check("rst_waitreq", m_waitrequest, 2'b11);
        check("rst_rdv", m_readdatavalid, 0);
        check("rst_err", err_rdv_unexpected, 0);

        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].m, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be);
            s_waitrequest = 1'b0;
            @(posedge clk_clk);
            @(negedge clk_clk);
            e = '1; e[vecs[i].m] = 1'b0;
            check("vec_s_read", s_read, vecs[i].exp_rd);
            check("vec_s_write", s_write, vecs[i].exp_wr);
            check("vec_s_address", s_address, vecs[i].addr);
            check("vec_s_writedata", s_writedata, vecs[i].data);
            check("vec_s_byteenable", s_byteenable, vecs[i].be);
            check("vec_release", m_waitrequest, e);
            @(posedge clk_clk); #1;
            clear_req();
            @(negedge clk_clk);
            check("vec_idle_wait", m_waitrequest, 2'b11);
            check("vec_idle_cmd", {s_read, s_write}, 2'b00);
        end

        // Controller stall: command held, release on first non-stalled cycle.
        do_reset();
        set_req(1, 1'b0, 1'b1, 22'h00ABCD, 16'h1234, 2'b01);
        s_waitrequest = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
            check("stall_s_write", s_write, 1);
            check("stall_s_address", s_address, 22'h00ABCD);
            check("stall_s_writedata", s_writedata, 16'h1234);
            check("stall_wait", m_waitrequest, 2'b11);
        end
        @(posedge clk_clk); #1;
        s_waitrequest = 1'b0;
        @(negedge clk_clk);
        check("stall_release", m_waitrequest, 2'b01);
        check("stall_s_write_end", s_write, 1);
        @(posedge clk_clk); #1;
        clear_req();
        @(negedge clk_clk);

        // Two masters reading continuously: grants and returns alternate.
        do_reset();
        model_en = 1'b1;
        set_req(0, 1'b1, 1'b0, 22'h000100, '0, '1);
        set_req(1, 1'b1, 1'b0, 22'h000200, '0, '1);
        exp_grant = '{0, 1, 0, 1};
        exp_rdv   = '{2'b01, 2'b10, 2'b01, 2'b10};
        gi = 0; rets = 0; acc[0] = 0; acc[1] = 0;
        for (int c = 0; c < 40 && rets < 4; c++) begin
            @(negedge clk_clk);
            for (int i = 0; i < N; i++) begin
                if (!m_waitrequest[i]) begin
                    if (gi < 4) check("alt_grant", i, exp_grant[gi]);
                    else check("alt_extra_grant", 1, 0);
                    gi++;
                    acc[i]++;
                end
            end
            if (m_readdatavalid != '0) begin
                check("alt_rdv", m_readdatavalid, exp_rdv[rets]);
                check("alt_rdata", m_readdata, ret_data[rets]);
                rets++;
            end
            @(posedge clk_clk); #1;
            for (int i = 0; i < N; i++) if (acc[i] >= 2) m_read[i] = 1'b0;
        end
        check("alt_returns", rets, 4);
        check("alt_grants", gi, 4);
        model_en = 1'b0;
        clear_req();
        @(negedge clk_clk);

        // Tag FIFO full: reads blocked, writes pass, one return unblocks.
        do_reset();
        for (int k = 0; k < 8; k++) issue_read(0, 22'(k));
        set_req(0, 1'b1, 1'b0, 22'h000055, '0, '1);
        repeat (3) @(negedge clk_clk);
        check("full_rd_blocked", s_read, 0);
        check("full_wait", m_waitrequest, 2'b11);
        set_req(1, 1'b0, 1'b1, 22'h000777, 16'h4321, 2'b11);
        @(posedge clk_clk);
        @(negedge clk_clk);
        check("full_wr_granted", {s_read, s_write}, 2'b01);
        check("full_wr_addr", s_address, 22'h000777);
        check("full_wr_release", m_waitrequest, 2'b01);
        @(posedge clk_clk); #1;
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_clk);
        check("full_rd_still_blocked", s_read, 0);
        tb_rdv = 1'b1;
        tb_rdata = 16'h5555;
        #1;
        check("full_ret_rdv", m_readdatavalid, 2'b01);
        check("full_ret_data", m_readdata, 16'h5555);
        @(posedge clk_clk); #1;
        tb_rdv = 1'b0;
        found = 0;
        for (int c = 0; c < 4 && found == 0; c++) begin
            @(negedge clk_clk);
            if (s_read) found = 1;
        end
        check("full_rd_regrant", found, 1);
        check("full_rd_addr", s_address, 22'h000055);

        // Read data with no pending tag.
        do_reset();
        tb_rdv = 1'b1;
        #1;
        check("empty_no_rdv", m_readdatavalid, 0);
        check("empty_err_before", err_rdv_unexpected, 0);
        @(posedge clk_clk); #1;
        tb_rdv = 1'b0;
        check("empty_err_set", err_rdv_unexpected, 1);
        repeat (5) @(negedge clk_clk);
        check("empty_err_sticky", err_rdv_unexpected, 1);

        // Reset during ISSUE with three reads outstanding.
        do_reset();
        for (int k = 0; k < 3; k++) issue_read(0, 22'(16 + k));
        set_req(1, 1'b1, 1'b0, 22'h000999, '0, '1);
        s_waitrequest = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);
        check("rstmid_issue", s_read, 1);
        reset_reset_n = 1'b0;
        #1;
        check("rstmid_s_read", s_read, 0);
        check("rstmid_wait", m_waitrequest, 2'b11);
        check("rstmid_addr", s_address, 0);
        clear_req();
        s_waitrequest = 1'b0;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("rstmid_err_clear", err_rdv_unexpected, 0);
        tb_rdv = 1'b1;
        #1;
        check("rstmid_fifo_empty", m_readdatavalid, 0);
        @(posedge clk_clk); #1;
        tb_rdv = 1'b0;
        check("rstmid_err_set", err_rdv_unexpected, 1);
        set_req(0, 1'b0, 1'b1, 22'h000AAA, 16'h1111, 2'b11);
        set_req(1, 1'b0, 1'b1, 22'h000BBB, 16'h2222, 2'b11);
        @(posedge clk_clk);
        @(negedge clk_clk);
        check("rstmid_rr_owner", m_waitrequest, 2'b10);
        check("rstmid_rr_addr", s_address, 22'h000AAA);
        @(posedge clk_clk); #1;
        clear_req();
        @(negedge clk_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
